// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX, EX/MEM and MEM/WB pipeline stages.
// Holds:
//   - the default datapath widths
//   - the NOP control encoding
//   - the occupancy state type used by the skid buffer
//   - the payload field layout, so every stage packs its fields the same way
// No ports (package).
package pipe_pkg;

  localparam int CTRL_W_DEF = 9;
  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int NOPS_DEF   = 2;

  // An all-zero control word decodes as a NOP in EX.
  localparam logic [CTRL_W_DEF-1:0] CTRL_NOP = '0;

  // Encoded so the state value doubles as the occupancy count.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_FULL  = 2'd2
  } occ_state_e;

  // Payload layout, LSB first: pc | rt | rd | ops | imm | ctrl.
  function automatic int off_pc();
    return 0;
  endfunction

  function automatic int off_rt(int data_w);
    return data_w;
  endfunction

  function automatic int off_rd(int data_w, int reg_w);
    return data_w + reg_w;
  endfunction

  function automatic int off_ops(int data_w, int reg_w);
    return data_w + 2*reg_w;
  endfunction

  function automatic int off_imm(int data_w, int nops, int reg_w);
    return data_w*(nops + 1) + 2*reg_w;
  endfunction

  function automatic int off_ctrl(int data_w, int nops, int reg_w);
    return data_w*(nops + 2) + 2*reg_w;
  endfunction

  function automatic int payload_w(int ctrl_w, int data_w, int nops, int reg_w);
    return ctrl_w + data_w*(nops + 2) + 2*reg_w;
  endfunction

  // Field offsets for the default widths.
  localparam int PL_OFF_PC   = off_pc();
  localparam int PL_OFF_RT   = off_rt(DATA_W_DEF);
  localparam int PL_OFF_RD   = off_rd(DATA_W_DEF, REG_W_DEF);
  localparam int PL_OFF_OPS  = off_ops(DATA_W_DEF, REG_W_DEF);
  localparam int PL_OFF_IMM  = off_imm(DATA_W_DEF, NOPS_DEF, REG_W_DEF);
  localparam int PL_OFF_CTRL = off_ctrl(DATA_W_DEF, NOPS_DEF, REG_W_DEF);
  localparam int PL_W        = payload_w(CTRL_W_DEF, DATA_W_DEF, NOPS_DEF, REG_W_DEF);

endpackage

// File: rtl/skid_buf.sv
// Generic 2-entry valid/ready skid buffer with flush and occupancy output.
// Entry M drives the output side and entry S absorbs one overflow word, so
// in_ready can come straight from a flop.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   flush                 drop both entries on the next edge
//   in_valid/in_ready     upstream handshake (in_ready registered)
//   in_data[W]            upstream payload
//   out_valid/out_ready   downstream handshake
//   out_data[W]           payload held in M
//   occ[2]                number of entries held (0..2)
module skid_buf
  import pipe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic [1:0]   occ
);

  occ_state_e   state_q, state_d;
  logic [W-1:0] m_q, m_d;
  logic [W-1:0] s_q, s_d;
  logic         in_ready_q;
  logic         accept;
  logic         issue;

  assign accept = in_valid & in_ready_q;
  assign issue  = (state_q != OCC_EMPTY) & out_ready;

  // Next-state logic. In OCC_FULL in_ready_q is 0, so no accept can happen there.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = OCC_EMPTY;
    end else begin
      case (state_q)
        OCC_EMPTY: begin
          if (accept) begin
            m_d     = in_data;
            state_d = OCC_ONE;
          end
        end
        OCC_ONE: begin
          if (issue && accept) begin
            m_d = in_data;
          end else if (issue) begin
            state_d = OCC_EMPTY;
          end else if (accept) begin
            s_d     = in_data;
            state_d = OCC_FULL;
          end
        end
        OCC_FULL: begin
          if (issue) begin
            m_d     = s_q;
            state_d = OCC_ONE;
          end
        end
        default: state_d = OCC_EMPTY;
      endcase
    end
  end

  // in_ready is precomputed from the next state so it has no path from out_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= OCC_EMPTY;
      m_q        <= '0;
      s_q        <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      s_q        <= s_d;
      in_ready_q <= (state_d != OCC_FULL);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != OCC_EMPTY);
  assign out_data  = m_q;
  assign occ       = state_q;

endmodule

// File: rtl/id_ex_skid_stage.sv
// ID-to-EX pipeline register with a valid/ready handshake.
// The stage:
//   - packs the decoded fields into one payload word
//   - buffers that word in a 2-entry skid buffer
//   - unpacks it for EX and masks the outputs during bubbles
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   flush                            squash all held instructions
//   in_valid/in_ready                ID handshake (in_ready registered)
//   in_ctrl/imm/ops/rd/rt/pc         decoded instruction from ID
//   out_valid/out_ready              EX handshake
//   out_ctrl/imm/ops/rd/rt/pc        registered instruction to EX
//   occ                              entries held (0..2)
module id_ex_skid_stage
  import pipe_pkg::*;
#(
  parameter int CTRL_W             = CTRL_W_DEF,
  parameter int DATA_W             = DATA_W_DEF,
  parameter int NOPS               = NOPS_DEF,
  parameter int REG_W              = REG_W_DEF,
  parameter int ZERO_ALL_ON_BUBBLE = 0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [CTRL_W-1:0]      in_ctrl,
  input  logic [DATA_W-1:0]      in_imm,
  input  logic [NOPS*DATA_W-1:0] in_ops,
  input  logic [REG_W-1:0]       in_rd,
  input  logic [REG_W-1:0]       in_rt,
  input  logic [DATA_W-1:0]      in_pc,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [CTRL_W-1:0]      out_ctrl,
  output logic [DATA_W-1:0]      out_imm,
  output logic [NOPS*DATA_W-1:0] out_ops,
  output logic [REG_W-1:0]       out_rd,
  output logic [REG_W-1:0]       out_rt,
  output logic [DATA_W-1:0]      out_pc,
  output logic [1:0]             occ
);

  localparam int PW       = payload_w(CTRL_W, DATA_W, NOPS, REG_W);
  localparam int OFF_PC   = off_pc();
  localparam int OFF_RT   = off_rt(DATA_W);
  localparam int OFF_RD   = off_rd(DATA_W, REG_W);
  localparam int OFF_OPS  = off_ops(DATA_W, REG_W);
  localparam int OFF_IMM  = off_imm(DATA_W, NOPS, REG_W);
  localparam int OFF_CTRL = off_ctrl(DATA_W, NOPS, REG_W);

  logic [PW-1:0] pl_in;
  logic [PW-1:0] pl_out;
  logic          valid;
  logic          bubble_zero;

  assign pl_in = {in_ctrl, in_imm, in_ops, in_rd, in_rt, in_pc};

  skid_buf #(
    .W (PW)
  ) u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (pl_in),
    .out_valid (valid),
    .out_ready (out_ready),
    .out_data  (pl_out),
    .occ       (occ)
  );

  assign out_valid = valid;

  // Masking sits after the register, so a bubble never disturbs the held payload.
  assign bubble_zero = (ZERO_ALL_ON_BUBBLE != 0) && !valid;

  assign out_ctrl = valid ? pl_out[OFF_CTRL +: CTRL_W] : CTRL_W'(CTRL_NOP);
  assign out_imm  = bubble_zero ? '0 : pl_out[OFF_IMM +: DATA_W];
  assign out_ops  = bubble_zero ? '0 : pl_out[OFF_OPS +: NOPS*DATA_W];
  assign out_rd   = bubble_zero ? '0 : pl_out[OFF_RD +: REG_W];
  assign out_rt   = bubble_zero ? '0 : pl_out[OFF_RT +: REG_W];
  assign out_pc   = bubble_zero ? '0 : pl_out[OFF_PC +: DATA_W];

endmodule

// File: tb/tb_id_ex_skid_stage.sv
// Scoreboard bench for id_ex_skid_stage.
// The driver pushes every accepted instruction into a queue. A monitor on the
// falling edge pops and compares whenever EX takes one. A second instance
// (NOPS=3, DATA_W=16, ZERO_ALL_ON_BUBBLE=1) covers full bubble masking.
module tb_id_ex_skid_stage;

  typedef struct packed {
    logic [8:0]  ctrl;
    logic [31:0] imm;
    logic [63:0] ops;
    logic [4:0]  rd;
    logic [4:0]  rt;
    logic [31:0] pc;
  } item_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid, in_ready;
  logic [8:0]  in_ctrl;
  logic [31:0] in_imm;
  logic [63:0] in_ops;
  logic [4:0]  in_rd, in_rt;
  logic [31:0] in_pc;
  logic        out_valid, out_ready;
  logic [8:0]  out_ctrl;
  logic [31:0] out_imm;
  logic [63:0] out_ops;
  logic [4:0]  out_rd, out_rt;
  logic [31:0] out_pc;
  logic [1:0]  occ;

  logic        zb_flush, zb_in_valid, zb_in_ready, zb_out_valid, zb_out_ready;
  logic [8:0]  zb_in_ctrl, zb_out_ctrl;
  logic [15:0] zb_in_imm, zb_out_imm, zb_in_pc, zb_out_pc;
  logic [47:0] zb_in_ops, zb_out_ops;
  logic [4:0]  zb_in_rd, zb_in_rt, zb_out_rd, zb_out_rt;
  logic [1:0]  zb_occ;

  item_t       sbQueue[$];
  int          nChecks = 0;
  int          nFail   = 0;
  logic        accepted;
  logic [31:0] lastImm = '0;

  id_ex_skid_stage dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_imm(in_imm), .in_ops(in_ops),
    .in_rd(in_rd), .in_rt(in_rt), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_imm(out_imm), .out_ops(out_ops),
    .out_rd(out_rd), .out_rt(out_rt), .out_pc(out_pc),
    .occ(occ)
  );

  id_ex_skid_stage #(
    .CTRL_W(9), .DATA_W(16), .NOPS(3), .REG_W(5), .ZERO_ALL_ON_BUBBLE(1)
  ) zb (
    .clk(clk), .rst_n(rst_n), .flush(zb_flush),
    .in_valid(zb_in_valid), .in_ready(zb_in_ready),
    .in_ctrl(zb_in_ctrl), .in_imm(zb_in_imm), .in_ops(zb_in_ops),
    .in_rd(zb_in_rd), .in_rt(zb_in_rt), .in_pc(zb_in_pc),
    .out_valid(zb_out_valid), .out_ready(zb_out_ready),
    .out_ctrl(zb_out_ctrl), .out_imm(zb_out_imm), .out_ops(zb_out_ops),
    .out_rd(zb_out_rd), .out_rt(zb_out_rt), .out_pc(zb_out_pc),
    .occ(zb_occ)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Every field is derived from the pc, so each instruction is distinguishable.
  function automatic item_t makeItem(input logic [31:0] pc);
    item_t it;
    it.ctrl = {pc[7:0], 1'b1};
    it.imm  = pc ^ 32'hFFFF_0000;
    it.ops  = {~pc, pc + 32'h0000_1000};
    it.rd   = pc[6:2];
    it.rt   = ~pc[6:2];
    it.pc   = pc;
    return it;
  endfunction

  task automatic checkOutput(input string name, input logic [127:0] act,
                             input logic [127:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one cycle, starting just after a rising edge. Acceptance is
  // sampled mid-cycle, and the queue is updated just after the next edge.
  task automatic applyStimulus(input logic v, input logic [31:0] pc,
                               input logic oready, input logic fl);
    item_t it;
    it        = makeItem(pc);
    in_valid  = v;
    in_ctrl   = it.ctrl;
    in_imm    = it.imm;
    in_ops    = it.ops;
    in_rd     = it.rd;
    in_rt     = it.rt;
    in_pc     = it.pc;
    out_ready = oready;
    flush     = fl;
    @(negedge clk);
    accepted = v && in_ready && !fl;
    @(posedge clk);
    #1;
    if (fl) sbQueue.delete();
    if (accepted) sbQueue.push_back(it);
  endtask

  // Keeps presenting one instruction until the stage takes it.
  task automatic sendInstr(input logic [31:0] pc, input logic oready);
    int tries;
    tries = 0;
    do begin
      applyStimulus(1'b1, pc, oready, 1'b0);
      tries++;
    end while (!accepted && tries < 8);
    if (!accepted) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL acceptTimeout: pc 0x%0h not accepted after %0d cycles", pc, tries);
    end
  endtask

  // Monitor: occupancy must match the queue depth, and each issue must match the head.
  always @(negedge clk) begin
    item_t exp;
    if (rst_n) begin
      checkOutput("occ", 128'(occ), 128'(sbQueue.size()));
      checkOutput("inReady", 128'(in_ready), 128'(sbQueue.size() < 2));
      checkOutput("outValid", 128'(out_valid), 128'(sbQueue.size() != 0));
      if (!out_valid) checkOutput("bubbleCtrl", 128'(out_ctrl), 128'(0));
      if (out_valid && out_ready && sbQueue.size() != 0) begin
        exp = sbQueue.pop_front();
        checkOutput("outPc", 128'(out_pc), 128'(exp.pc));
        checkOutput("outCtrl", 128'(out_ctrl), 128'(exp.ctrl));
        checkOutput("outImm", 128'(out_imm), 128'(exp.imm));
        checkOutput("outOps", 128'(out_ops), 128'(exp.ops));
        checkOutput("outRd", 128'(out_rd), 128'(exp.rd));
        checkOutput("outRt", 128'(out_rt), 128'(exp.rt));
        lastImm = exp.imm;
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = '0; in_imm = '0; in_ops = '0; in_rd = '0; in_rt = '0; in_pc = '0;
    zb_flush = 1'b0; zb_in_valid = 1'b0; zb_out_ready = 1'b0;
    zb_in_ctrl = '0; zb_in_imm = '0; zb_in_ops = '0;
    zb_in_rd = '0; zb_in_rt = '0; zb_in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rstInReady", 128'(in_ready), 128'(1));
    checkOutput("rstOutValid", 128'(out_valid), 128'(0));
    checkOutput("rstOcc", 128'(occ), 128'(0));
    checkOutput("rstImm", 128'(out_imm), 128'(0));
    checkOutput("rstOps", 128'(out_ops), 128'(0));
    checkOutput("rstPc", 128'(out_pc), 128'(0));
    rst_n = 1'b1;

    // Back-to-back stream with EX always ready.
    for (int i = 0; i < 8; i++) sendInstr(32'(i*4), 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    // With ZERO_ALL_ON_BUBBLE=0 the immediate of pc 0x1C stays visible.
    checkOutput("immRetained", 128'(out_imm), 128'(32'hFFFF_001C));
    checkOutput("immRetainedModel", 128'(out_imm), 128'(lastImm));

    // Three stall cycles: M then S fill, and in_ready drops.
    sendInstr(32'h20, 1'b0);
    sendInstr(32'h24, 1'b0);
    checkOutput("stallInReady", 128'(in_ready), 128'(0));
    checkOutput("stallOcc", 128'(occ), 128'(2));
    applyStimulus(1'b1, 32'h28, 1'b0, 1'b0);
    sendInstr(32'h28, 1'b1);
    sendInstr(32'h2C, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset with both entries full, between clock edges.
    sendInstr(32'h30, 1'b0);
    sendInstr(32'h34, 1'b0);
    checkOutput("preRstOcc", 128'(occ), 128'(2));
    #1 rst_n = 1'b0;
    #1;
    checkOutput("midRstInReady", 128'(in_ready), 128'(1));
    checkOutput("midRstOcc", 128'(occ), 128'(0));
    checkOutput("midRstOutValid", 128'(out_valid), 128'(0));
    checkOutput("midRstCtrl", 128'(out_ctrl), 128'(0));
    checkOutput("midRstImm", 128'(out_imm), 128'(0));
    checkOutput("midRstPc", 128'(out_pc), 128'(0));
    sbQueue.delete();
    #1 rst_n = 1'b1;

    // Flush with both entries full while pc 0x40 is presented.
    sendInstr(32'h38, 1'b0);
    sendInstr(32'h3C, 1'b0);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b1);
    checkOutput("flushOcc", 128'(occ), 128'(0));
    checkOutput("flushOutValid", 128'(out_valid), 128'(0));
    checkOutput("flushCtrl", 128'(out_ctrl), 128'(0));
    checkOutput("flushInReady", 128'(in_ready), 128'(1));
    // Flush on the same cycle as a real accept and an issue: 0x44 issues, 0x48 is dropped.
    sendInstr(32'h44, 1'b0);
    applyStimulus(1'b1, 32'h48, 1'b1, 1'b1);
    checkOutput("flush2Occ", 128'(occ), 128'(0));
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    sendInstr(32'h50, 1'b1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);

    // Full bubble masking on the second instance.
    zb_in_valid = 1'b1; zb_in_ctrl = 9'h1A3; zb_in_imm = 16'hBEEF;
    zb_in_ops = 48'h1111_2222_3333; zb_in_rd = 5'd7; zb_in_rt = 5'd9;
    zb_in_pc = 16'h0100; zb_out_ready = 1'b0;
    @(posedge clk); #1;
    checkOutput("zbValid", 128'(zb_out_valid), 128'(1));
    checkOutput("zbCtrl", 128'(zb_out_ctrl), 128'(9'h1A3));
    checkOutput("zbImm", 128'(zb_out_imm), 128'(16'hBEEF));
    checkOutput("zbOps", 128'(zb_out_ops), 128'(48'h1111_2222_3333));
    checkOutput("zbPc", 128'(zb_out_pc), 128'(16'h0100));
    zb_in_valid = 1'b0; zb_out_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("zbBubbleValid", 128'(zb_out_valid), 128'(0));
    checkOutput("zbBubbleCtrl", 128'(zb_out_ctrl), 128'(0));
    checkOutput("zbBubbleImm", 128'(zb_out_imm), 128'(0));
    checkOutput("zbBubbleOps", 128'(zb_out_ops), 128'(0));
    checkOutput("zbBubbleRd", 128'(zb_out_rd), 128'(0));
    checkOutput("zbBubbleRt", 128'(zb_out_rt), 128'(0));
    checkOutput("zbBubblePc", 128'(zb_out_pc), 128'(0));

    // Bounded drain; anything left in the queue was lost.
    for (int i = 0; i < 10 && sbQueue.size() != 0; i++)
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    if (sbQueue.size() != 0) begin
      nChecks++;
      nFail++;
      $display("[TB] FAIL drain: %0d instructions never issued", sbQueue.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
